// File: rtl/memory_hs_ctrl_if.sv
// Request/response bus of memory_hs_ctrl.
//   valid_i, wr_rd_en_i, addr_i, wdata_i, wstrb_i : requester -> memory
//   rdata_o, ready_o, err_o, busy_o               : memory -> requester
// Signal suffixes are named from the memory's point of view.
interface memory_hs_ctrl_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  valid_i;
    logic                  wr_rd_en_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [WIDTH-1:0]      wdata_i;
    logic [WIDTH/8-1:0]    wstrb_i;
    logic [WIDTH-1:0]      rdata_o;
    logic                  ready_o;
    logic                  err_o;
    logic                  busy_o;

    modport master (
        output valid_i, wr_rd_en_i, addr_i, wdata_i, wstrb_i,
        input  rdata_o, ready_o, err_o, busy_o
    );

    modport slave (
        input  valid_i, wr_rd_en_i, addr_i, wdata_i, wstrb_i,
        output rdata_o, ready_o, err_o, busy_o
    );
endinterface

// File: rtl/memory_hs_ctrl.sv
// Single-port scratchpad memory behind a valid/ready request handshake.
// Byte-strobed writes, configurable read latency (1..4), error response for
// addresses >= DEPTH and an optional zeroing sweep after reset.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : memory_hs_ctrl_if.slave (request in, rdata/ready/err/busy out)
module memory_hs_ctrl #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDR_WIDTH    = $clog2(DEPTH),
    parameter int unsigned RD_LATENCY    = 2,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    memory_hs_ctrl_if.slave bus
);
    localparam int unsigned NumBytes = WIDTH / 8;
    // RD_WAIT lasts LatLoad+1 cycles, giving RD_LATENCY total from accept to ready.
    localparam int unsigned LatLoad  = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

    typedef enum logic [1:0] {StInit, StIdle, StRdWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] sweep_q;
    logic [1:0]            lat_q;
    logic [WIDTH-1:0]      rdata_q;
    logic                  err_q;

    logic [WIDTH-1:0]      mem [DEPTH];

    logic                  accept;
    logic                  addr_oor;
    logic                  sweep_last;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [NumBytes-1:0]   mem_wstrb;

    assign accept     = (state_q == StIdle) && bus.valid_i;
    assign addr_oor   = 32'(bus.addr_i) >= DEPTH;
    assign sweep_last = sweep_q == ADDR_WIDTH'(DEPTH - 1);

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= INIT_ON_RESET ? StInit : StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit: begin
                if (sweep_last) state_d = StIdle;
            end
            StIdle: begin
                if (bus.valid_i) begin
                    if (addr_oor || bus.wr_rd_en_i || (RD_LATENCY == 1)) begin
                        state_d = StResp;
                    end else begin
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (lat_q == 2'd0) state_d = StResp;
            end
            StResp: begin
                // No sampling here: the next request can only be accepted from IDLE.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs and memory write port
    always_comb begin
        bus.ready_o = 1'b0;
        bus.busy_o  = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = sweep_q;
        mem_wdata   = '0;
        mem_wstrb   = '1;
        unique case (state_q)
            StInit: begin
                bus.busy_o = 1'b1;
                mem_we     = 1'b1;
            end
            StIdle: begin
                if (accept && bus.wr_rd_en_i && !addr_oor) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.addr_i;
                    mem_wdata = bus.wdata_i;
                    mem_wstrb = bus.wstrb_i;
                end
            end
            StResp: begin
                bus.ready_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.rdata_o = rdata_q;
    assign bus.err_o   = err_q;

    // Request datapath
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sweep_q <= '0;
            addr_q  <= '0;
            lat_q   <= 2'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    sweep_q <= sweep_last ? '0 : sweep_q + 1'b1;
                end
                StIdle: begin
                    if (accept) begin
                        addr_q <= bus.addr_i;
                        lat_q  <= 2'(LatLoad);
                        err_q  <= addr_oor;
                        if (!bus.wr_rd_en_i) begin
                            if (addr_oor) begin
                                rdata_q <= '0;
                            end else if (RD_LATENCY == 1) begin
                                rdata_q <= mem[bus.addr_i];
                            end
                        end
                    end
                end
                StRdWait: begin
                    if (lat_q == 2'd0) begin
                        rdata_q <= mem[addr_q];
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                StResp: begin
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Storage: no reset, zeroed by the sweep when enabled
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (mem_wstrb[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end
endmodule
